aes_dma_ctrl: RTL
=================

Name: aes_dma_ctrl

Overview:
- APB master / stream bridge directly upstream and downstream of the AES APB peripheral.
- Services the peripheral's DMA request pair.
  - Write request: pulls 32-bit words from an input stream and writes each block into the data-input register.
  - Read request: reads each result block from the data-output register and pushes it onto an output stream.
- The AES peripheral is its only APB slave. Zero-wait-state slaves are supported, and so is PREADY stretching.

Parameters:
- DINR_ADDR, 32'h0000_0008, APB byte address of the AES data-input register.
- DOUTR_ADDR, 32'h0000_000C, APB byte address of the AES data-output register.
- BLOCK_WORDS, 4, 32-bit words per AES block per burst (range 1..15).

Ports:
- clk  in  1  single clock, shared with the AES peripheral PCLK.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new burst starts; an active burst runs to completion.
- dma_req  in  2  from the AES peripheral: bit1 = input-data write request, bit0 = output-data read request.
- s_data  in  32  input stream data (plaintext or ciphertext words).
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- m_data  out  32  output stream data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.
- err  out  1  sticky: a transfer ended with PSLVERR.
- err_clr  in  1  clears err.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- **Reset:** synchronous. On the rst cycle all outputs go to 0, PADDR/PWDATA/m_data go to 0, state = IDLE, pending flags cleared, word counter = 0. rst has priority over everything, including mid-transfer (PSEL drops the next cycle).
- **Request detection:** dma_req is registered.
  - A 0->1 edge on bit1 sets wr_pend; a 0->1 edge on bit0 sets rd_pend.
  - A pending flag clears on the cycle its burst leaves IDLE.
  - A level held high across a burst does not retrigger.
- **Arbitration in IDLE** (only if enable = 1): rd_pend wins over wr_pend, so results are drained before new input. Counter is loaded to 0.
- **States and transitions:**
  - **IDLE:** -> RD_SETUP if rd_pend; else -> WR_FETCH if wr_pend.
  - **WR_FETCH:** s_ready = 1. On s_valid & s_ready, latch s_data into PWDATA -> WR_SETUP.
  - **WR_SETUP:** PSEL = 1, PENABLE = 0, PWRITE = 1, PADDR = DINR_ADDR -> WR_ACCESS.
  - **WR_ACCESS:** PSEL = 1, PENABLE = 1; hold until PREADY. On PREADY, counter++.
    - Counter == BLOCK_WORDS-1 -> IDLE.
    - Otherwise -> WR_FETCH.
  - **RD_SETUP:** PSEL = 1, PENABLE = 0, PWRITE = 0, PADDR = DOUTR_ADDR -> RD_ACCESS.
  - **RD_ACCESS:** hold until PREADY. On PREADY, capture PRDATA into m_data, m_valid = 1 -> RD_PUSH.
  - **RD_PUSH:** m_valid held and m_data stable until m_ready. On the handshake, counter++.
    - Last word -> IDLE.
    - Otherwise -> RD_SETUP.
- **Throughput:** minimum 3 cycles per write word (FETCH/SETUP/ACCESS) and 3 per read word with PREADY = 1 and the stream always ready.
- **APB rules:**
  - PADDR/PWRITE/PWDATA are stable from SETUP through the PREADY cycle.
  - PSEL is 0 in IDLE, WR_FETCH and RD_PUSH.
- **Error:** PSLVERR sampled with PREADY in an ACCESS state sets err and aborts the burst to IDLE.
  - On a read error, m_valid is not asserted.
  - err_clr clears err unless a new error is set in the same cycle; a new error wins.
- **Simultaneous edges:** both request edges in the same cycle set both flags; read runs first, then write.
- **enable low:** pending flags are retained, not dropped.

Test Plan:
- Write burst: dma_req edge 00->10, s_data 11111111, 22222222, 33333333, 44444444 always valid, PREADY = 1 -> four APB writes to 0x08 with that data, each SETUP->ACCESS of 2 cycles; s_ready pulses 4 times; busy drops 12 cycles after start.
- Read burst: dma_req 00->01, PRDATA AAAA0000+n, m_ready toggling 1/0 -> four APB reads of 0x0C; m_data sequence AAAA0000..AAAA0003; m_data held while m_ready = 0.
- Wait states: PREADY low 3 cycles on word 2 -> PENABLE and PADDR/PWDATA held constant; no duplicate or skipped word.
- Both edges in the same cycle (dma_req 00->11) -> full read burst completes before the first write SETUP.
- PSLVERR on write word 1 -> err = 1, burst aborts to IDLE; err_clr pulse -> err = 0; a new dma_req edge restarts from word 0.
- Reset mid-burst (during RD_ACCESS) -> next cycle PSEL = PENABLE = m_valid = busy = 0; a pending write edge is lost.

Source files
------------

// File: rtl/aes_dma_ctrl.sv
// rtl/aes_dma_ctrl.sv - APB master / stream bridge servicing the AES peripheral DMA request pair
module aes_dma_ctrl #(
  parameter logic [31:0] DINR_ADDR   = 32'h0000_0008,
  parameter logic [31:0] DOUTR_ADDR  = 32'h0000_000C,
  parameter int          BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  dma_req,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        err,
  input  logic        err_clr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    RD_PUSH
  } state_t;

  // Counter value of the final word in a block burst.
  localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

  state_t      state_q;
  logic [1:0]  req_q;
  logic [1:0]  req_qq;
  logic        wr_pend_q;
  logic        rd_pend_q;
  logic [3:0]  cnt_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic        pwrite_q;
  logic        psel_q;
  logic        penable_q;
  logic        s_ready_q;
  logic [31:0] m_data_q;
  logic        m_valid_q;
  logic        err_q;
  logic        busy_q;
  logic [1:0]  req_rise;

  // Rising edges of the registered request lines; a held level never retriggers.
  assign req_rise = req_q & ~req_qq;

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign s_ready = s_ready_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign err     = err_q;
  assign busy    = busy_q;

  // Request capture, read-first arbitration and the burst FSM driving registered APB/stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 2'b00;
      req_qq    <= 2'b00;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      cnt_q     <= 4'd0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      s_ready_q <= 1'b0;
      m_data_q  <= 32'h0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      req_q  <= dma_req;
      req_qq <= req_q;
      // A new error later in this block overrides the clear.
      if (err_clr) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (enable && rd_pend_q) begin
            rd_pend_q <= 1'b0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b1;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= DOUTR_ADDR;
            state_q   <= RD_SETUP;
          end else if (enable && wr_pend_q) begin
            wr_pend_q <= 1'b0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
            state_q   <= WR_FETCH;
          end
        end

        WR_FETCH: begin
          if (s_valid && s_ready_q) begin
            pwdata_q  <= s_data;
            s_ready_q <= 1'b0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b1;
            paddr_q   <= DINR_ADDR;
            state_q   <= WR_SETUP;
          end
        end

        WR_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= WR_ACCESS;
        end

        WR_ACCESS: begin
          if (PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (PSLVERR) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (cnt_q == LAST_WORD) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q     <= cnt_q + 4'd1;
              s_ready_q <= 1'b1;
              state_q   <= WR_FETCH;
            end
          end
        end

        RD_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= RD_ACCESS;
        end

        RD_ACCESS: begin
          if (PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (PSLVERR) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              m_data_q  <= PRDATA;
              m_valid_q <= 1'b1;
              state_q   <= RD_PUSH;
            end
          end
        end

        RD_PUSH: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (cnt_q == LAST_WORD) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q     <= cnt_q + 4'd1;
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              pwrite_q  <= 1'b0;
              paddr_q   <= DOUTR_ADDR;
              state_q   <= RD_SETUP;
            end
          end
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase

      // New edges are recorded last so an edge arriving as a burst starts is not lost.
      if (req_rise[1]) wr_pend_q <= 1'b1;
      if (req_rise[0]) rd_pend_q <= 1'b1;
    end
  end

endmodule
